uart_tx_fifo: RTL

Parametrised UART transmitter with integrated baud divider and transmit FIFO. It generalises the single-byte transmitter to configurable data width, parity, stop bits and buffer depth. Frames stream back-to-back with no idle gap while the FIFO holds data. It sits behind the CPU bus peripheral logic; the bus side pushes bytes, the block drives the serial line.

---
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO and an integrated baud divider.
// Frames stream back-to-back while the FIFO holds data; tx comes straight from a flop.
module uart_tx_fifo #(
  parameter int DIVIDE    = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic [DATA_BITS-1:0]   in,
  input  logic                   we,
  output logic                   ready,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   overflow,
  input  logic                   clr_ovf,
  output logic                   tx
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIVIDE);

  if (DIVIDE < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      !(STOP_BITS == 1 || STOP_BITS == 2) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_err
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end, start_frame;

  // ready reflects the pre-edge level, so a full FIFO drops a write even if it pops this edge
  assign ready    = (level_q != LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign push     = we && ready;
  assign head     = mem_q[rptr_q];
  assign level_d  = level_q + LW'(push) - LW'(pop);

  always_ff @(posedge wb_clk) begin
    if (push) mem_q[wptr_q] <= in;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      if (we && !ready) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign bit_end = (cnt_q == CW'(DIVIDE - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    par_d       = par_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    if (state_q == S_IDLE) begin
      tx_d = 1'b1;
      if (!empty) start_frame = 1'b1;
    end else if (!bit_end) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          bit_d   = '0;
        end
        S_DATA: begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
        S_STOP: begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            if (!empty) start_frame = 1'b1;
            else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Pop and launch the start bit on the same edge; parity is frozen from the popped word
    if (start_frame) begin
      pop     = 1'b1;
      state_d = S_START;
      sh_d    = head;
      par_d   = (PARITY == 1) ? ~(^head) : (^head);
      tx_d    = 1'b0;
      cnt_d   = '0;
      bit_d   = '0;
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    tx   = tx_q;
  end
endmodule
